instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/cpu_pkg.sv | 40 ++++
 rtl/instr_fifo.sv | 58 +++++
 rtl/instr_fetch.sv | 137 +++++++++++++
 tb/tb_instr_fetch.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, instruction field positions,
// fetch FSM states and the fetch buffer entry layout.
package cpu_pkg;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0100;
    localparam logic [3:0] OP_LW    = 4'b1011;
    localparam logic [3:0] OP_SW    = 4'b1111;
    localparam logic [3:0] OP_BEQ   = 4'b1000;
    localparam logic [3:0] OP_J     = 4'b0010;

    localparam int OPC_HI  = 15;
    localparam int OPC_LO  = 12;
    localparam int RS_HI   = 11;
    localparam int RS_LO   = 9;
    localparam int RT_HI   = 8;
    localparam int RT_LO   = 6;
    localparam int RD_HI   = 5;
    localparam int RD_LO   = 3;
    localparam int FUNC_HI = 2;
    localparam int FUNC_LO = 0;
    localparam int JT_HI   = 7;
    localparam int JT_LO   = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [7:0]  pc;
        logic [15:0] instr;
    } fetch_entry_t;

    function automatic logic [7:0] pc_inc(input logic [7:0] pc);
        return pc + 8'd1;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Fetch buffer: DEPTH-entry FIFO of {pc, instr} with a one-cycle flush.
module instr_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [7:0]    push_pc,
    input  logic [15:0]   push_instr,
    input  logic          pop,
    output logic [7:0]    head_pc,
    output logic [15:0]   head_instr,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr].pc    <= push_pc;
                mem[wptr].instr <= push_instr;
                wptr            <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    assign head_pc    = mem[rptr].pc;
    assign head_instr = mem[rptr].instr;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: single-outstanding memory requester feeding
// a small instruction buffer, with redirect flush and stale-response drop.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter int         DEPTH    = 2,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          imem_req,
    output logic [7:0]    imem_addr,
    input  logic          imem_gnt,
    input  logic          imem_rvalid,
    input  logic [15:0]   imem_rdata,
    output logic          id_valid,
    input  logic          id_ready,
    output logic [15:0]   id_instr,
    output logic [7:0]    id_pc,
    output logic [3:0]    id_opcode,
    output logic [2:0]    id_func,
    input  logic          redirect,
    input  logic [7:0]    redirect_pc,
    output logic [CW-1:0] buf_count
);

    localparam int CW1 = CW + 1;

    fetch_state_t state;
    fetch_state_t state_n;
    logic [7:0]   pc;
    logic [7:0]   pc_n;
    logic [7:0]   gnt_pc;
    logic [7:0]   gnt_pc_n;
    logic         discard;
    logic         discard_n;
    logic         push;
    logic         pop;
    logic [CW1-1:0] count_after;
    logic         space_after;

    assign pop  = id_valid && id_ready && !redirect;
    assign push = (state == WAIT) && imem_rvalid
                  && !discard && !redirect;

    assign count_after = {1'b0, buf_count}
                         + CW1'(push) - CW1'(pop);
    assign space_after = count_after < CW1'(DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            gnt_pc   <= RESET_PC;
            discard  <= 1'b0;
            imem_req <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            gnt_pc   <= gnt_pc_n;
            discard  <= discard_n;
            imem_req <= (state_n == REQ);
        end
    end

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        gnt_pc_n  = gnt_pc;
        discard_n = discard;
        unique case (state)
            IDLE: begin
                if (buf_count < CW'(DEPTH)) begin
                    state_n = REQ;
                end
            end
            REQ: begin
                if (imem_gnt) begin
                    state_n  = WAIT;
                    gnt_pc_n = pc;
                    pc_n     = pc_inc(pc);
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    discard_n = 1'b0;
                    state_n   = space_after ? REQ : IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        // A redirect wins over everything; a request already granted
        // still owes us a response, which must be thrown away.
        if (redirect) begin
            pc_n = redirect_pc;
            unique case (state)
                IDLE: state_n = REQ;
                REQ: begin
                    if (imem_gnt) begin
                        discard_n = 1'b1;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        discard_n = 1'b0;
                        state_n   = REQ;
                    end else begin
                        discard_n = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    instr_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect),
        .push       (push),
        .push_pc    (gnt_pc),
        .push_instr (imem_rdata),
        .pop        (pop),
        .head_pc    (id_pc),
        .head_instr (id_instr),
        .count      (buf_count)
    );

    assign imem_addr = pc;
    assign id_valid  = (buf_count != '0);
    assign id_opcode = id_instr[OPC_HI:OPC_LO];
    assign id_func   = id_instr[FUNC_HI:FUNC_LO];

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: random memory timing, stalls,
// redirects and resets against a sequential-PC reference stream.
module tb_instr_fetch;
    import cpu_pkg::*;

    localparam logic [7:0] RPC   = 8'h00;
    localparam int         DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [15:0] id_instr;
    logic [7:0]  id_pc;
    logic [3:0]  id_opcode;
    logic [2:0]  id_func;
    logic        redirect = 1'b0;
    logic [7:0]  redirect_pc = '0;
    logic [1:0]  buf_count;

    instr_fetch #(
        .RESET_PC(RPC),
        .DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_instr   (id_instr),
        .id_pc      (id_pc),
        .id_opcode  (id_opcode),
        .id_func    (id_func),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .buf_count  (buf_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    logic [15:0] mem [256];

    // Reference: fetch stream is sequential from the last reset/redirect.
    typedef struct {
        logic [7:0]  pc;
        logic [15:0] instr;
    } exp_t;
    exp_t       sbq [$];
    logic [7:0] mpc;
    int         delivered = 0;

    function automatic void refill();
        while (sbq.size() < 4) begin
            sbq.push_back('{mpc, mem[mpc]});
            mpc = mpc + 8'd1;
        end
    endfunction

    function automatic void restart(input logic [7:0] p);
        sbq.delete();
        mpc = p;
        refill();
    endfunction

    // Memory model: drives at the falling edge, samples grants 3 ns later.
    int         gnt_mode = 0;
    int         dmin = 1;
    int         dmax = 1;
    logic       pend = 1'b0;
    int         dcnt = 0;
    logic [7:0] raddr = '0;

    always begin
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = 16'($urandom);
        if (pend) begin
            dcnt--;
            if (dcnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem[raddr];
                pend        = 1'b0;
            end
        end
        case (gnt_mode)
            0:       imem_gnt = 1'b1;
            1:       imem_gnt = 1'($urandom_range(0, 1));
            default: imem_gnt = 1'b0;
        endcase
        #3;
        if (imem_req && imem_gnt) begin
            check("one_outstanding", 32'(pend), 0);
            pend  = 1'b1;
            dcnt  = int'($urandom_range(dmin, dmax));
            raddr = imem_addr;
        end
    end

    always begin : monitor
        exp_t e;
        @(negedge clk);
        #3;
        if (rst_n && !redirect && id_valid && id_ready) begin
            e = sbq.pop_front();
            check("id_pc", 32'(id_pc), 32'(e.pc));
            check("id_instr", 32'(id_instr), 32'(e.instr));
            check("id_opc_func", 32'({id_opcode, id_func}),
                  32'({e.instr[15:12], e.instr[2:0]}));
            refill();
            delivered++;
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_deliv(input int n, input int budget);
        int start = delivered;
        int k = 0;
        while ((delivered - start) < n && k < budget) begin
            cyc();
            k++;
        end
        check("progress", 32'((delivered - start) >= n), 1);
    endtask

    task automatic redir(input logic [7:0] p);
        redirect    = 1'b1;
        redirect_pc = p;
        restart(p);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_req"}, 32'(imem_req), 0);
        check({tag, "_valid"}, 32'(id_valid), 0);
        check({tag, "_count"}, 32'(buf_count), 0);
        check({tag, "_pc"}, 32'(id_pc), 0);
        check({tag, "_instr"}, 32'(id_instr), 0);
    endtask

    task automatic wait_wait_state(input string tag);
        int k = 0;
        while (!(pend && !imem_rvalid) && k < 100) begin
            cyc();
            k++;
        end
        check({tag, "_found"}, 32'(pend && !imem_rvalid), 1);
    endtask

    initial begin
        int k;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'($urandom);
        end
        restart(RPC);
        #1 rst_n = 1'b0;
        cyc();
        #1 check_reset("reset");

        cyc();
        rst_n    = 1'b1;
        id_ready = 1'b1;
        wait_deliv(20, 200);

        // Stall decode: buffer fills and requests stop.
        cyc();
        id_ready = 1'b0;
        repeat (10) cyc();
        #1;
        check("stall_count", 32'(buf_count), DEPTH);
        check("stall_req", 32'(imem_req), 0);
        id_ready = 1'b1;
        wait_deliv(10, 200);

        // PC wrap 8'hFF -> 8'h00.
        cyc();
        redir(8'hFC);
        cyc();
        redirect = 1'b0;
        wait_deliv(8, 200);

        // Redirect while a response is pending.
        dmin = 3;
        dmax = 3;
        cyc();
        wait_wait_state("wait_redir");
        redir(8'h40);
        cyc();
        redirect = 1'b0;
        #1;
        check("wait_flush_count", 32'(buf_count), 0);
        check("wait_flush_valid", 32'(id_valid), 0);
        wait_deliv(4, 100);

        // Redirect in the same cycle as the response.
        dmin = 1;
        k = 0;
        while (!imem_rvalid && k < 100) begin
            cyc();
            k++;
        end
        check("rv_redir_found", 32'(imem_rvalid), 1);
        redir(8'h20);
        cyc();
        redirect = 1'b0;
        #1 check("rv_redir_count", 32'(buf_count), 0);
        wait_deliv(4, 100);

        // Redirect while requesting without a grant.
        gnt_mode = 2;
        cyc();
        k = 0;
        while (!imem_req && k < 100) begin
            cyc();
            k++;
        end
        check("nogrant_found", 32'(imem_req), 1);
        redir(8'h80);
        cyc();
        redirect = 1'b0;
        #1;
        check("nogrant_req", 32'(imem_req), 1);
        check("nogrant_addr", 32'(imem_addr), 32'h80);
        gnt_mode = 0;
        wait_deliv(4, 100);

        // Randomized traffic.
        gnt_mode = 1;
        dmax = 4;
        k = delivered;
        for (int i = 0; i < 1500; i++) begin
            cyc();
            id_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) begin
                redir(8'($urandom));
            end else begin
                redirect = 1'b0;
            end
        end
        cyc();
        redirect = 1'b0;
        id_ready = 1'b1;
        check("random_progress", 32'((delivered - k) > 100), 1);

        // Reset mid-WAIT, response lands during reset.
        gnt_mode = 0;
        dmin = 3;
        dmax = 3;
        repeat (3) cyc();
        wait_wait_state("rst_wait");
        rst_n = 1'b0;
        restart(RPC);
        #1 check_reset("midrst");
        for (int i = 0; i < 4; i++) begin
            cyc();
            #1;
            check("midrst_valid", 32'(id_valid), 0);
            check("midrst_count", 32'(buf_count), 0);
        end
        cyc();
        rst_n = 1'b1;
        dmin = 1;
        dmax = 2;
        wait_deliv(6, 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
